msi_bus_memory: RTL
===================

// Module: msi_bus_memory
// PURPOSE
//  Memory-side responder of the MSI snooping bus: services read-miss, write-miss, invalidate and write-back
//  requests issued by a cache controller. Each miss or invalidate is broadcast to the snooping caches.
//  Any snooper abort (a line held Modified) is honoured: the memory access is cancelled and the data comes
//  from the snooper's write-back. Sits between the cache controllers and a small on-chip memory array.
// PARAMETERS
//  ADDR_W       4  address width; memory depth is 2**ADDR_W words
//  DATA_W       8  data word width
//  MEM_LATENCY  3  memory read latency in cycles (>=1)
//  SNOOP_WIN    2  cycles after broadcast during which abort_memory_access is sampled (>=1)
//  WB_TIMEOUT   8  cycles allowed for a snooper write-back (used only with MSI_WB_TIMEOUT_EN)
// PORTS
//  clock                input   1       single clock, rising edge
//  resetn               input   1       asynchronous active-low reset
//  req_valid            input   1       request present from initiating cache
//  req_type             input   2       00 readMiss, 01 writeMiss, 10 invalidate, 11 writeBack
//  req_addr             input   ADDR_W  request address
//  req_wdata            input   DATA_W  write-back data (req_type=11 only)
//  req_ready            output  1       responder idle, accepts request this cycle
//  snoop_read_miss      output  1       one-cycle broadcast pulse
//  snoop_write_miss     output  1       one-cycle broadcast pulse
//  snoop_invalidate     output  1       one-cycle broadcast pulse
//  snoop_addr           output  ADDR_W  latched request address, stable from BCAST until DONE
//  abort_memory_access  input   1       snooper holds line Modified; cancel memory read
//  snoop_write_back     input   1       snooper write-back data valid
//  snoop_wdata          input   DATA_W  snooper write-back data
//  resp_valid           output  1       one-cycle completion pulse
//  resp_rdata           output  DATA_W  response data, valid with resp_valid
//  resp_from_cache      output  1       1 = resp_rdata supplied by snooper write-back
//  current_state        output  3       FSM state encoding, for LED/HEX debug
// BEHAVIOUR
//  - Reset: all outputs 0 except req_ready=1; FSM=IDLE(0); counters 0; memory contents not reset.
//  - IDLE(0): req_ready=1. req_valid=1 latches type/addr/wdata -> BCAST; writeBack -> MWR.
//  - BCAST(1): 1 cycle; pulse snoop_* matching type; invalidate -> DONE; read/write miss -> SNOOP.
//  - SNOOP(2): SNOOP_WIN cycles. Abort seen in any cycle -> WAITWB; else after window -> MRD.
//  - MRD(3): MEM_LATENCY cycles, then resp_rdata <= mem[addr] -> DONE (resp_from_cache=0).
//  - WAITWB(4): on snoop_write_back: mem[addr] <= snoop_wdata; resp_rdata <= snoop_wdata;
//    resp_from_cache=1 -> DONE. Waits indefinitely unless MSI_WB_TIMEOUT_EN.
//  - MWR(5): mem[addr] <= latched wdata, 1 cycle -> DONE.
//  - DONE(6): resp_valid=1 for exactly 1 cycle -> IDLE. Invalidate and writeBack give resp_rdata=0.
//  - Latency, accept to resp_valid: invalidate 2, writeBack 2, miss without abort 2+SNOOP_WIN+MEM_LATENCY.
//  - Abort and snoop_write_back in the same SNOOP cycle: write-back taken immediately, WAITWB skipped.
//  - abort_memory_access outside SNOOP, and snoop_write_back outside SNOOP/WAITWB: ignored.
//  - req_valid while req_ready=0: ignored. Requester must hold the request until accepted.
//  - resetn asserted mid-transaction: FSM to IDLE at once. Pending memory write lost; no resp_valid.
//  - Counters wrap-safe: sized to hold max(MEM_LATENCY, SNOOP_WIN, WB_TIMEOUT).
// CONFIGURATION
//  - MSI_WB_TIMEOUT_EN defined: WAITWB counts WB_TIMEOUT cycles. On expiry -> MRD (data from memory).
//    Sticky output wb_timeout_err (1 bit, cleared only by reset) is set.
//  - Macro undefined: no timeout counter, no wb_timeout_err port, WAITWB waits indefinitely.
// TESTING
//  1. Reset, then readMiss addr=3 with mem[3]=8'hA5, no abort:
//     snoop_read_miss pulses 1 cycle after accept; resp_valid at accept+7; rdata=A5, from_cache=0.
//  2. writeMiss addr=5, abort in 2nd SNOOP cycle, write-back 8'h3C two cycles later:
//     resp_rdata=3C, from_cache=1; a following readMiss addr=5 returns 3C.
//  3. writeBack addr=9 wdata=8'h77: no snoop pulses; resp_valid at accept+2; later readMiss addr=9 returns 77.
//  4. invalidate addr=2: snoop_invalidate 1 pulse; resp_valid at accept+2; abort during BCAST ignored.
//  5. Abort and write-back 8'h11 in the same SNOOP cycle: no WAITWB cycle; rdata=11. resetn low in MRD:
//     IDLE next cycle, req_ready=1, no resp_valid.
//  6. MSI_WB_TIMEOUT_EN: abort, no write-back: after 8 WAITWB cycles memory read occurs;
//     wb_timeout_err=1 until reset.

Source files
------------

// File: rtl/msi_bus_memory.sv
// Memory-side responder for an MSI snooping bus: broadcasts misses/invalidates, honours snooper aborts.
// Optional MSI_WB_TIMEOUT_EN bounds the snooper write-back wait and adds sticky wb_timeout_err.
module msi_bus_memory #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned MEM_LATENCY = 3,
  parameter int unsigned SNOOP_WIN   = 2,
  parameter int unsigned WB_TIMEOUT  = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  input  logic [1:0]        req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              snoop_read_miss,
  output logic              snoop_write_miss,
  output logic              snoop_invalidate,
  output logic [ADDR_W-1:0] snoop_addr,
  input  logic              abort_memory_access,
  input  logic              snoop_write_back,
  input  logic [DATA_W-1:0] snoop_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_from_cache,
`ifdef MSI_WB_TIMEOUT_EN
  output logic              wb_timeout_err,
`endif
  output logic [2:0]        current_state
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned MAX_AB  = (MEM_LATENCY > SNOOP_WIN) ? MEM_LATENCY : SNOOP_WIN;
  localparam int unsigned CNT_MAX = (MAX_AB > WB_TIMEOUT) ? MAX_AB : WB_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] T_READ_MISS  = 2'b00;
  localparam logic [1:0] T_WRITE_MISS = 2'b01;
  localparam logic [1:0] T_INVALIDATE = 2'b10;
  localparam logic [1:0] T_WRITE_BACK = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BCAST  = 3'd1,
    S_SNOOP  = 3'd2,
    S_MRD    = 3'd3,
    S_WAITWB = 3'd4,
    S_MWR    = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t            state;
  logic [1:0]        type_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;

  assign current_state = state;

  // Memory write port: latched write-back data or a snooper's flushed line.
  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = wdata_q;
    case (state)
      S_MWR: mem_we = 1'b1;
      S_SNOOP: if (abort_memory_access && snoop_write_back) begin
        mem_we    = 1'b1;
        mem_wdata = snoop_wdata;
      end
      S_WAITWB: if (snoop_write_back) begin
        mem_we    = 1'b1;
        mem_wdata = snoop_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[snoop_addr] <= mem_wdata;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state            <= S_IDLE;
      req_ready        <= 1'b1;
      snoop_read_miss  <= 1'b0;
      snoop_write_miss <= 1'b0;
      snoop_invalidate <= 1'b0;
      snoop_addr       <= '0;
      type_q           <= '0;
      wdata_q          <= '0;
      cnt              <= '0;
      resp_valid       <= 1'b0;
      resp_rdata       <= '0;
      resp_from_cache  <= 1'b0;
`ifdef MSI_WB_TIMEOUT_EN
      wb_timeout_err   <= 1'b0;
`endif
    end else begin
      snoop_read_miss  <= 1'b0;
      snoop_write_miss <= 1'b0;
      snoop_invalidate <= 1'b0;
      resp_valid       <= 1'b0;
      case (state)
        S_IDLE: if (req_valid) begin
          type_q          <= req_type;
          snoop_addr      <= req_addr;
          wdata_q         <= req_wdata;
          req_ready       <= 1'b0;
          cnt             <= '0;
          resp_rdata      <= '0;
          resp_from_cache <= 1'b0;
          if (req_type == T_WRITE_BACK) begin
            state <= S_MWR;
          end else begin
            state            <= S_BCAST;
            snoop_read_miss  <= (req_type == T_READ_MISS);
            snoop_write_miss <= (req_type == T_WRITE_MISS);
            snoop_invalidate <= (req_type == T_INVALIDATE);
          end
        end
        S_BCAST: begin
          cnt <= '0;
          if (type_q == T_INVALIDATE) begin
            state      <= S_DONE;
            resp_valid <= 1'b1;
          end else begin
            state <= S_SNOOP;
          end
        end
        // Abort with same-cycle write-back completes directly from the snooper.
        S_SNOOP: begin
          if (abort_memory_access) begin
            cnt <= '0;
            if (snoop_write_back) begin
              state           <= S_DONE;
              resp_valid      <= 1'b1;
              resp_rdata      <= snoop_wdata;
              resp_from_cache <= 1'b1;
            end else begin
              state <= S_WAITWB;
            end
          end else if (cnt == CNT_W'(SNOOP_WIN - 1)) begin
            state <= S_MRD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_MRD: begin
          if (cnt == CNT_W'(MEM_LATENCY - 1)) begin
            state           <= S_DONE;
            resp_valid      <= 1'b1;
            resp_rdata      <= mem[snoop_addr];
            resp_from_cache <= 1'b0;
            cnt             <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WAITWB: begin
          if (snoop_write_back) begin
            state           <= S_DONE;
            resp_valid      <= 1'b1;
            resp_rdata      <= snoop_wdata;
            resp_from_cache <= 1'b1;
          end
`ifdef MSI_WB_TIMEOUT_EN
          // Snooper never flushed: fall back to the (possibly stale) memory copy.
          else if (cnt == CNT_W'(WB_TIMEOUT - 1)) begin
            state          <= S_MRD;
            cnt            <= '0;
            wb_timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
        S_MWR: begin
          state      <= S_DONE;
          resp_valid <= 1'b1;
        end
        S_DONE: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
